// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Brief    : Register-file write-port arbiter: in-order WB results win over a
//            queue of long-latency results, with stale-kill, pending mask and
//            starvation stall request.
// Revision : 1.0  initial release
// ============================================================================
module regfile_writeback #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_reg,
    input  logic [DW-1:0]     wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [AW-1:0]     lu_reg,
    input  logic [DW-1:0]     lu_data,
    output logic              regWrite,
    output logic [AW-1:0]     writeReg,
    output logic [DW-1:0]     writeData,
    output logic [2**AW-1:0]  pending_mask,
    output logic              stall_req
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_SW = $clog2(STARVE_MAX + 1);

    // FIFO storage; unoccupied slots always carry valid=0
    logic [DEPTH-1:0]  r_vld;
    logic [AW-1:0]     r_reg  [DEPTH];
    logic [DW-1:0]     r_data [DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;
    logic [c_SW-1:0]   r_starve;

    logic              w_alu_wr;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_head_vld;
    logic [AW-1:0]     w_head_reg;
    logic [DW-1:0]     w_head_data;
    logic [DEPTH-1:0]  w_vld_nxt;
    logic [AW-1:0]     w_reg_nxt [DEPTH];
    logic [2**AW-1:0]  w_mask_nxt;

    assign w_alu_wr    = wb_valid & (wb_reg != '0);
    assign w_empty     = (r_count == '0);
    assign w_pop       = ~w_alu_wr & ~w_empty;
    assign lu_ready    = rst_n & (r_count < c_CW'(DEPTH));
    // A zero-destination transfer completes the handshake but is dropped
    assign w_push      = lu_valid & lu_ready & (lu_reg != '0);

    assign w_head_vld  = r_vld[r_rptr];
    assign w_head_reg  = r_reg[r_rptr];
    assign w_head_data = r_data[r_rptr];

    // Slot update: pop frees, push fills, then an ALU write kills matching entries
    always_comb begin
        w_vld_nxt = r_vld;
        for (int i = 0; i < DEPTH; i++) begin
            w_reg_nxt[i] = r_reg[i];
            if (w_pop && (r_rptr == c_PW'(i))) begin
                w_vld_nxt[i] = 1'b0;
            end
            if (w_push && (r_wptr == c_PW'(i))) begin
                w_vld_nxt[i] = 1'b1;
                w_reg_nxt[i] = lu_reg;
            end
            if (w_alu_wr && (w_reg_nxt[i] == wb_reg)) begin
                w_vld_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_mask_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld_nxt[i]) begin
                w_mask_nxt[w_reg_nxt[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld        <= '0;
            pending_mask <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld        <= w_vld_nxt;
            pending_mask <= w_mask_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i] <= w_reg_nxt[i];
            end
            if (w_push) begin
                r_data[r_wptr] <= lu_data;
            end
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count consecutive cycles where queued work loses to the ALU path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve  <= '0;
            stall_req <= 1'b0;
        end else if (w_empty || w_pop) begin
            r_starve  <= '0;
            stall_req <= 1'b0;
        end else if (r_starve == c_SW'(STARVE_MAX - 1)) begin
            r_starve  <= '0;
            stall_req <= 1'b1;
        end else begin
            r_starve  <= r_starve + c_SW'(1);
            stall_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else if (w_alu_wr) begin
            regWrite  <= 1'b1;
            writeReg  <= wb_reg;
            writeData <= wb_data;
        end else if (w_pop) begin
            regWrite  <= w_head_vld;
            writeReg  <= w_head_reg;
            writeData <= w_head_data;
        end else begin
            regWrite  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Brief    : Directed table, corner sequences and random traffic against a
//            queue-based reference model of the write-back arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_writeback;
    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_valid;
    logic [AW-1:0]     wb_reg;
    logic [DW-1:0]     wb_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [AW-1:0]     lu_reg;
    logic [DW-1:0]     lu_data;
    logic              regWrite;
    logic [AW-1:0]     writeReg;
    logic [DW-1:0]     writeData;
    logic [2**AW-1:0]  pending_mask;
    logic              stall_req;

    regfile_writeback #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .pending_mask(pending_mask), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue of pending results
    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        bit            v;
    } ent_t;

    ent_t           q[$];
    bit             m_rw;
    logic [AW-1:0]  m_wr;
    logic [DW-1:0]  m_wd;
    bit             m_stall;
    int             m_starve;

    typedef struct {
        bit            wv;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        bit            lv;
        logic [AW-1:0] lr;
        logic [DW-1:0] ld;
        bit            e_rw;
        logic [AW-1:0] e_wr;
        logic [DW-1:0] e_wd;
        logic [31:0]   e_mask;
        bit            e_stall;
        bit            e_rdy;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(bit wv, int wr, int wd, bit lv, int lr, int ld,
                                bit rw, int ewr, int ewd, int msk, bit st, bit rdy);
        vec_t v;
        v.wv = wv; v.wr = AW'(wr); v.wd = DW'(wd);
        v.lv = lv; v.lr = AW'(lr); v.ld = DW'(ld);
        v.e_rw = rw; v.e_wr = AW'(ewr); v.e_wd = DW'(ewd);
        v.e_mask = 32'(msk); v.e_stall = st; v.e_rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].v) m[q[i].r] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rw = 1'b0; m_wr = '0; m_wd = '0; m_stall = 1'b0; m_starve = 0;
    endtask

    task automatic model_step();
        bit   alu, was_empty, ready, pop;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        alu       = wb_valid && (wb_reg != 0);
        was_empty = (q.size() == 0);
        ready     = (q.size() < DEPTH);
        pop       = !alu && !was_empty;
        if (alu) begin
            m_rw = 1'b1; m_wr = wb_reg; m_wd = wb_data;
        end else if (pop) begin
            e = q.pop_front();
            m_rw = e.v; m_wr = e.r; m_wd = e.d;
        end else begin
            m_rw = 1'b0;
        end
        if (lu_valid && ready && lu_reg != 0) begin
            e.r = lu_reg; e.d = lu_data; e.v = 1'b1;
            q.push_back(e);
        end
        if (alu) foreach (q[i]) if (q[i].r == wb_reg) q[i].v = 1'b0;
        if (was_empty || pop) begin
            m_starve = 0; m_stall = 1'b0;
        end else begin
            m_starve++;
            m_stall = (m_starve == STARVE_MAX);
            if (m_stall) m_starve = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("regWrite", {63'd0, regWrite}, {63'd0, m_rw});
        chk("writeReg", 64'(writeReg), 64'(m_wr));
        chk("writeData", 64'(writeData), 64'(m_wd));
        chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
        chk("stall_req", {63'd0, stall_req}, {63'd0, m_stall});
        chk("lu_ready", {63'd0, lu_ready}, {63'd0, (rst_n && q.size() < DEPTH)});
    endtask

    task automatic drive(bit wv, int wr, int wd, bit lv, int lr, int ld);
        wb_valid = wv; wb_reg = AW'(wr); wb_data = DW'(wd);
        lu_valid = lv; lu_reg = AW'(lr); lu_data = DW'(ld);
    endtask

    initial begin
        // ALU path, queue fill/drain, full+pop, stale-kill, same-cycle kill, reg-0 drop
        tbl[0]  = mk(1,5,'h1234, 0,0,0,       1,5,'h1234,   'h0,    0,1);
        tbl[1]  = mk(1,0,'hDEAD, 0,0,0,       0,5,'h1234,   'h0,    0,1);
        tbl[2]  = mk(1,1,'h11,   1,8,'h80,    1,1,'h11,     'h100,  0,1);
        tbl[3]  = mk(1,1,'h12,   1,9,'h90,    1,1,'h12,     'h300,  0,1);
        tbl[4]  = mk(1,1,'h13,   1,10,'hA0,   1,1,'h13,     'h700,  0,1);
        tbl[5]  = mk(1,1,'h14,   1,11,'hB0,   1,1,'h14,     'hF00,  0,0);
        tbl[6]  = mk(0,0,0,      1,12,'hC0,   1,8,'h80,     'hE00,  0,1);
        tbl[7]  = mk(0,0,0,      1,12,'hC0,   1,9,'h90,     'h1C00, 0,1);
        tbl[8]  = mk(0,0,0,      0,0,0,       1,10,'hA0,    'h1800, 0,1);
        tbl[9]  = mk(0,0,0,      0,0,0,       1,11,'hB0,    'h1000, 0,1);
        tbl[10] = mk(0,0,0,      0,0,0,       1,12,'hC0,    'h0,    0,1);
        tbl[11] = mk(0,0,0,      1,7,'hAAAA,  0,12,'hC0,    'h80,   0,1);
        tbl[12] = mk(1,7,'h5555, 0,0,0,       1,7,'h5555,   'h0,    0,1);
        tbl[13] = mk(0,0,0,      0,0,0,       0,7,'hAAAA,   'h0,    0,1);
        tbl[14] = mk(0,0,0,      0,0,0,       0,7,'hAAAA,   'h0,    0,1);
        tbl[15] = mk(1,6,'h66,   1,6,'h77,    1,6,'h66,     'h0,    0,1);
        tbl[16] = mk(0,0,0,      0,0,0,       0,6,'h77,     'h0,    0,1);
        tbl[17] = mk(0,0,0,      1,0,'h99,    0,6,'h77,     'h0,    0,1);
        tbl[18] = mk(0,0,0,      0,0,0,       0,6,'h77,     'h0,    0,1);

        rst_n = 1'b0;
        drive(0,0,0,0,0,0);
        model_reset();
        #1;
        chk("rst_regWrite", {63'd0, regWrite}, 64'd0);
        chk("rst_mask", 64'(pending_mask), 64'd0);
        chk("rst_lu_ready", {63'd0, lu_ready}, 64'd0);
        repeat (2) cycle();
        #2 rst_n = 1'b1;
        #1 chk("rel_lu_ready", {63'd0, lu_ready}, 64'd1);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].wv, int'(tbl[i].wr), int'(tbl[i].wd),
                  tbl[i].lv, int'(tbl[i].lr), int'(tbl[i].ld));
            cycle();
            chk($sformatf("tbl%0d_rw", i), {63'd0, regWrite}, {63'd0, tbl[i].e_rw});
            chk($sformatf("tbl%0d_wr", i), 64'(writeReg), 64'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_wd", i), 64'(writeData), 64'(tbl[i].e_wd));
            chk($sformatf("tbl%0d_mask", i), 64'(pending_mask), 64'(tbl[i].e_mask));
            chk($sformatf("tbl%0d_stall", i), {63'd0, stall_req}, {63'd0, tbl[i].e_stall});
            chk($sformatf("tbl%0d_rdy", i), {63'd0, lu_ready}, {63'd0, tbl[i].e_rdy});
        end

        // Starvation: r3 queued, ALU wins eight times in a row
        drive(0,0,0, 1,3,'h33);
        cycle();
        for (int k = 0; k < STARVE_MAX; k++) begin
            drive(1,2,k, 0,0,0);
            cycle();
            chk($sformatf("t5_stall_%0d", k), {63'd0, stall_req}, {63'd0, (k == STARVE_MAX-1)});
        end
        drive(0,0,0, 0,0,0);
        cycle();
        chk("t5_rw", {63'd0, regWrite}, 64'd1);
        chk("t5_wr", 64'(writeReg), 64'd3);
        chk("t5_wd", 64'(writeData), 64'h33);
        chk("t5_stall_low", {63'd0, stall_req}, 64'd0);

        // Stall ignored by upstream: ALU still wins, entry survives
        drive(0,0,0, 1,3,'h34);
        cycle();
        for (int k = 0; k <= STARVE_MAX; k++) begin
            drive(1,2,'h100 + k, 0,0,0);
            cycle();
        end
        chk("t5v_rw", {63'd0, regWrite}, 64'd1);
        chk("t5v_wr", 64'(writeReg), 64'd2);
        chk("t5v_stall", {63'd0, stall_req}, 64'd0);
        chk("t5v_mask", 64'(pending_mask), 64'h8);
        drive(0,0,0, 0,0,0);
        cycle();
        chk("t5v_pop_wd", 64'(writeData), 64'h34);

        // Reset in the middle of traffic with entries queued
        drive(1,1,'h1, 1,4,'h44);
        cycle();
        drive(1,1,'h2, 1,5,'h55);
        cycle();
        chk("t1_pre_mask", 64'(pending_mask), 64'h30);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1_rw", {63'd0, regWrite}, 64'd0);
        chk("t1_mask", 64'(pending_mask), 64'd0);
        chk("t1_lu_ready", {63'd0, lu_ready}, 64'd0);
        repeat (2) cycle();
        #2 rst_n = 1'b1;
        #1 chk("t1_rel_ready", {63'd0, lu_ready}, 64'd1);
        drive(0,0,0, 0,0,0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("t1_nowrite_%0d", k), {63'd0, regWrite}, 64'd0);
        end

        // Random traffic at three ALU densities, small register range for collisions
        for (int p = 0; p < 3; p++) begin
            int pct;
            pct = (p == 0) ? 30 : ((p == 1) ? 70 : 95);
            for (int n = 0; n < 200; n++) begin
                drive(($urandom_range(0, 99) < pct), $urandom_range(0, 7), $urandom,
                      $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
